// File: rtl/cadb_responder.sv
// cadb_responder: target end of the host debug link.
// Decodes read/write packets, runs one memory access, replies through tx.
module cadb_responder #(
  parameter int unsigned TIMEOUT  = 1000000,
  parameter logic [7:0]  ACK_BYTE = 8'h4B,
  parameter logic [7:0]  ERR_BYTE = 8'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [31:0] IDLE_LAST =
    32'(TIMEOUT) - 32'd1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    MEM,
    SEND,
    SEND_WAIT
  } stateT;

  stateT       state;
  logic        isWrite;
  logic [1:0]  byteCnt;
  logic [31:0] idleCnt;
  logic [31:0] addrSh;
  logic [31:0] dataSh;
  logic [31:0] respBuf;
  logic [2:0]  respLeft;
  logic        waited;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      isWrite   <= 1'b0;
      byteCnt   <= 2'd0;
      idleCnt   <= '0;
      addrSh    <= '0;
      dataSh    <= '0;
      respBuf   <= '0;
      respLeft  <= 3'd0;
      waited    <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_valid) begin
            byteCnt <= 2'd0;
            idleCnt <= '0;
            if (rx_data == CMD_RD ||
                rx_data == CMD_WR) begin
              isWrite <= (rx_data == CMD_WR);
              state   <= ADDR;
            end else begin
              respBuf  <= {ERR_BYTE, 24'h0};
              respLeft <= 3'd1;
              state    <= SEND;
            end
          end
        end
        ADDR: begin
          if (rx_valid) begin
            idleCnt <= '0;
            addrSh  <= {addrSh[23:0], rx_data};
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) begin
              byteCnt <= 2'd0;
              if (isWrite) begin
                state <= WDATA;
              end else begin
                mem_addr <= {addrSh[23:0], rx_data};
                state    <= MEM;
              end
            end
          end else if (idleCnt >= IDLE_LAST) begin
            idleCnt <= '0;
            state   <= IDLE;
          end else begin
            idleCnt <= idleCnt + 32'd1;
          end
        end
        WDATA: begin
          if (rx_valid) begin
            idleCnt <= '0;
            dataSh  <= {dataSh[23:0], rx_data};
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) begin
              byteCnt   <= 2'd0;
              mem_addr  <= addrSh;
              mem_wdata <= {dataSh[23:0], rx_data};
              state     <= MEM;
            end
          end else if (idleCnt >= IDLE_LAST) begin
            idleCnt <= '0;
            state   <= IDLE;
          end else begin
            idleCnt <= idleCnt + 32'd1;
          end
        end
        MEM: begin
          // Request rises one cycle after entry; ack ends it.
          if (!mem_re && !mem_we) begin
            mem_re <= !isWrite;
            mem_we <= isWrite;
          end else if (mem_ack) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (isWrite) begin
              respBuf  <= {ACK_BYTE, 24'h0};
              respLeft <= 3'd1;
            end else begin
              respBuf  <= mem_rdata;
              respLeft <= 3'd4;
            end
            state <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= respBuf[31:24];
            respBuf  <= {respBuf[23:0], 8'h00};
            respLeft <= respLeft - 3'd1;
            waited   <= 1'b0;
            state    <= SEND_WAIT;
          end
        end
        SEND_WAIT: begin
          // tx_busy only rises a cycle after tx_start.
          if (!waited) begin
            waited <= 1'b1;
          end else if (!tx_busy) begin
            state <= (respLeft != 3'd0) ?
                     SEND : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cadb_responder.sv
// tb_cadb_responder: randomized packets against a packet-level model.
// Transmitter and memory are behavioural responders with random timing.
module tb_cadb_responder;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  cadb_responder #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_re(mem_re),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .busy(busy)
  );

  int vecs = 0;
  int errs = 0;

  function automatic logic [31:0] defData(
    input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  // Transmitter responder and tx monitor
  logic       txBusyM = 1'b0;
  logic       txHold = 1'b0;
  int         txLen = 2;
  int         txCnt = 0;
  int         cyc = 0;
  int         fallCyc = -1;
  int         maxGap = 0;
  int         consecStart = 0;
  int         startBusy = 0;
  logic       prevStart = 1'b0;
  logic       prevBusy = 1'b0;
  logic [7:0] txQ[$];

  assign tx_busy = txBusyM | txHold;

  always @(posedge clk) begin
    cyc++;
    if (tx_start) begin
      txQ.push_back(tx_data);
      if (prevStart) consecStart++;
      if (tx_busy) startBusy++;
      if (fallCyc >= 0 && cyc - fallCyc > maxGap)
        maxGap = cyc - fallCyc;
      fallCyc = -1;
    end else if (prevBusy && !tx_busy) begin
      fallCyc = cyc;
    end
    prevStart = tx_start;
    prevBusy = tx_busy;
    if (!rst_n) begin
      txBusyM <= 1'b0;
      txCnt = 0;
    end else if (tx_start) begin
      txBusyM <= 1'b1;
      txCnt = txLen;
    end else if (txBusyM) begin
      if (txCnt <= 1) txBusyM <= 1'b0;
      else txCnt--;
    end
  end

  // Memory responder and request monitor
  logic        memHold = 1'b0;
  int          ackDly = 0;
  int          bursts = 0;
  int          instab = 0;
  int          bothReq = 0;
  logic        prevReq = 1'b0;
  logic [31:0] prevA = '0;
  logic [31:0] prevD = '0;
  logic        opWe[$];
  logic [31:0] opA[$];
  logic [31:0] opD[$];
  logic [31:0] memArr[logic [31:0]];

  always @(posedge clk) begin
    if ((mem_re || mem_we) && !prevReq) bursts++;
    if (mem_re && mem_we) bothReq++;
    if ((mem_re || mem_we) && prevReq &&
        (mem_addr !== prevA ||
         (mem_we && mem_wdata !== prevD)))
      instab++;
    prevReq = mem_re || mem_we;
    prevA = mem_addr;
    prevD = mem_wdata;
    mem_rdata <= $urandom();
    if (!rst_n) begin
      mem_ack <= 1'b0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
    end else if ((mem_re || mem_we) && !memHold) begin
      if (ackDly == 0) begin
        mem_ack <= 1'b1;
        ackDly = $urandom_range(0, 4);
        opWe.push_back(mem_we);
        opA.push_back(mem_addr);
        opD.push_back(mem_wdata);
        if (mem_we) memArr[mem_addr] = mem_wdata;
        mem_rdata <= memArr.exists(mem_addr) ?
                     memArr[mem_addr] : defData(mem_addr);
      end else begin
        ackDly--;
      end
    end
  end

  // Packet-level reference model
  logic [7:0]  pktQ[$];
  logic [7:0]  expTx[$];
  int          expN = 0;
  logic        expWe = 1'b0;
  logic [31:0] expA = '0;
  logic [31:0] expD = '0;
  logic [31:0] refMem[logic [31:0]];

  task automatic modelPacket();
    logic [31:0] a;
    logic [31:0] d;
    expTx.delete();
    expN = 0;
    if (pktQ[0] == 8'h52) begin
      a = {pktQ[1], pktQ[2], pktQ[3], pktQ[4]};
      d = refMem.exists(a) ? refMem[a] : defData(a);
      for (int i = 3; i >= 0; i--)
        expTx.push_back(d[8*i +: 8]);
      expN = 1; expWe = 1'b0; expA = a; expD = d;
    end else if (pktQ[0] == 8'h57) begin
      a = {pktQ[1], pktQ[2], pktQ[3], pktQ[4]};
      d = {pktQ[5], pktQ[6], pktQ[7], pktQ[8]};
      refMem[a] = d;
      expTx.push_back(8'h4B);
      expN = 1; expWe = 1'b1; expA = a; expD = d;
    end else begin
      expTx.push_back(8'h3F);
    end
  endtask

  task automatic clearObs();
    txQ.delete();
    opWe.delete();
    opA.delete();
    opD.delete();
    bursts = 0;
    fallCyc = -1;
  endtask

  task automatic sendByte(input logic [7:0] b,
                          input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'($urandom());
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendPacket(input int gapMax);
    foreach (pktQ[i])
      sendByte(pktQ[i], $urandom_range(0, gapMax));
  endtask

  task automatic waitDone(input string nm);
    int n = 0;
    while ((busy || tx_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (busy || tx_busy) begin
      errs++;
      $display("FAIL %s idle-wait: busy=%b required 0",
               nm, busy);
    end
  endtask

  task automatic scoreboardPacket(input string nm);
    int n;
    vecs++;
    if (txQ.size() != expTx.size()) begin
      errs++;
      $display("FAIL %s tx-count: got %0d required %0d",
               nm, txQ.size(), expTx.size());
    end
    n = (txQ.size() < expTx.size()) ?
        txQ.size() : expTx.size();
    for (int i = 0; i < n; i++) begin
      vecs++;
      if (txQ[i] !== expTx[i]) begin
        errs++;
        $display("FAIL %s tx[%0d]: got %h required %h",
                 nm, i, txQ[i], expTx[i]);
      end
    end
    vecs++;
    if (opWe.size() != expN || bursts != expN) begin
      errs++;
      $display("FAIL %s mem-ops: got %0d/%0d required %0d",
               nm, opWe.size(), bursts, expN);
    end
    if (expN == 1 && opWe.size() == 1) begin
      vecs++;
      if (opWe[0] !== expWe || opA[0] !== expA ||
          (expWe && opD[0] !== expD)) begin
        errs++;
        $display("FAIL %s mem-op: got we=%b a=%h d=%h required we=%b a=%h d=%h",
                 nm, opWe[0], opA[0], opD[0],
                 expWe, expA, expD);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 ||
        mem_re !== 1'b0 || mem_we !== 1'b0 ||
        busy !== 1'b0) begin
      errs++;
      $display("FAIL reset-ctl: got %b%b%b%b d=%h required 0000 d=00",
               tx_start, mem_re, mem_we, busy, tx_data);
    end
    vecs++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errs++;
      $display("FAIL reset-mem: got a=%h d=%h required 0",
               mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    memArr[32'h0000_1004] = 32'hDEAD_BEEF;
    refMem[32'h0000_1004] = 32'hDEAD_BEEF;
    pktQ = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h04};
    clearObs();
    modelPacket();
    txLen = 3;
    sendPacket(2);
    waitDone("read");
    scoreboardPacket("read");
  endtask

  task automatic test_write();
    pktQ = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h08,
             8'h12, 8'h34, 8'h56, 8'h78};
    clearObs();
    modelPacket();
    txLen = 2;
    sendPacket(0);
    sendByte(8'h41, 0);
    waitDone("write");
    scoreboardPacket("write");
    vecs++;
    if (instab != 0) begin
      errs++;
      $display("FAIL write-hold: got %0d changes required 0",
               instab);
    end
  endtask

  task automatic test_unknown();
    pktQ = '{8'h41};
    clearObs();
    modelPacket();
    sendPacket(1);
    waitDone("unknown");
    scoreboardPacket("unknown");
  endtask

  task automatic test_timeout();
    clearObs();
    sendByte(8'h52, 0);
    sendByte(8'h00, 0);
    repeat (TO - 10) @(negedge clk);
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL timeout-early: busy=%b required 1", busy);
    end
    repeat (15) @(negedge clk);
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL timeout-abort: busy=%b required 0", busy);
    end
    vecs++;
    if (txQ.size() != 0 || bursts != 0) begin
      errs++;
      $display("FAIL timeout-quiet: tx=%0d bursts=%0d required 0",
               txQ.size(), bursts);
    end
    pktQ = '{8'h41};
    clearObs();
    modelPacket();
    sendPacket(0);
    waitDone("timeout-next");
    scoreboardPacket("timeout-next");
  endtask

  task automatic test_backpressure();
    int n = 0;
    pktQ = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h1C};
    clearObs();
    modelPacket();
    txLen = 1;
    sendPacket(1);
    txHold = 1'b1;
    while (opWe.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (50) @(negedge clk);
    vecs++;
    if (txQ.size() != 0) begin
      errs++;
      $display("FAIL bp-hold: got %0d starts required 0",
               txQ.size());
    end
    txHold = 1'b0;
    waitDone("backpressure");
    scoreboardPacket("backpressure");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    pktQ = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
    clearObs();
    memHold = 1'b1;
    sendPacket(1);
    while (!mem_re && n < 40) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (mem_re !== 1'b1) begin
      errs++;
      $display("FAIL rstmid-req: mem_re=%b required 1", mem_re);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++;
    if (mem_re !== 1'b0 || busy !== 1'b0 ||
        tx_start !== 1'b0 || mem_addr !== 32'h0) begin
      errs++;
      $display("FAIL rstmid-async: re=%b busy=%b a=%h required 0",
               mem_re, busy, mem_addr);
    end
    repeat (3) @(negedge clk);
    memHold = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    vecs++;
    if (txQ.size() != 0 || opWe.size() != 0) begin
      errs++;
      $display("FAIL rstmid-quiet: tx=%0d ops=%0d required 0",
               txQ.size(), opWe.size());
    end
    pktQ = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h04};
    clearObs();
    modelPacket();
    sendPacket(1);
    waitDone("rstmid-read");
    scoreboardPacket("rstmid-read");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  b;
    int          kind;
    for (int k = 0; k < 30; k++) begin
      kind = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 7)) << 2;
      if ($urandom_range(0, 3) == 0) a = $urandom();
      d = $urandom();
      pktQ.delete();
      if (kind == 2) begin
        b = 8'($urandom());
        while (b == 8'h52 || b == 8'h57)
          b = 8'($urandom());
        pktQ.push_back(b);
      end else begin
        pktQ.push_back(kind == 0 ? 8'h52 : 8'h57);
        for (int i = 3; i >= 0; i--)
          pktQ.push_back(a[8*i +: 8]);
        if (kind == 1)
          for (int i = 3; i >= 0; i--)
            pktQ.push_back(d[8*i +: 8]);
      end
      txLen = $urandom_range(1, 5);
      clearObs();
      modelPacket();
      sendPacket(3);
      waitDone($sformatf("rand%0d", k));
      scoreboardPacket($sformatf("rand%0d", k));
    end
  endtask

  task automatic test_back_to_back();
    vecs++;
    if (consecStart != 0 || startBusy != 0) begin
      errs++;
      $display("FAIL tx-pulse: consec=%0d whileBusy=%0d required 0",
               consecStart, startBusy);
    end
    vecs++;
    if (maxGap > 2) begin
      errs++;
      $display("FAIL tx-latency: got %0d cycles required <=2",
               maxGap);
    end
    vecs++;
    if (instab != 0 || bothReq != 0) begin
      errs++;
      $display("FAIL mem-req: unstable=%0d both=%0d required 0",
               instab, bothReq);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unknown();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/cadb_responder.md
CADB_RESPONDER -- requirements
Module: cadb_responder

Interface
REQ-001 Parameter: TIMEOUT, default 1000000, the number of idle clk cycles between bytes that aborts a partially received packet.
REQ-002 Parameter: ACK_BYTE, default 8'h4B, the response byte for a completed write.
REQ-003 Parameter: ERR_BYTE, default 8'h3F, the response byte for an unknown command.
REQ-004 Port: clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-005 Port: rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-006 Port: rx_valid, input, 1 bit, a one-cycle strobe that marks rx_data as a new byte from the serial receiver.
REQ-007 Port: rx_data, input, 8 bits, the received byte; it is valid only while rx_valid=1.
REQ-008 Port: tx_start, output, 1 bit, a one-cycle request that the serial transmitter send tx_data.
REQ-009 Port: tx_data, output, 8 bits, the byte to send; it is held stable until the transmitter finishes with it.
REQ-010 Port: tx_busy, input, 1 bit, transmitter busy; it rises the cycle after an accepted tx_start.
REQ-011 Port: mem_addr, output, 32 bits, the memory word address.
REQ-012 Port: mem_wdata, output, 32 bits, the memory write data.
REQ-013 Port: mem_re, output, 1 bit, the read request.
REQ-014 Port: mem_we, output, 1 bit, the write request.
REQ-015 Port: mem_rdata, input, 32 bits, the read data; it is valid while mem_ack=1.
REQ-016 Port: mem_ack, input, 1 bit, request complete; it is a one-cycle pulse.
REQ-017 Port: busy, output, 1 bit, asserted whenever the FSM is not in IDLE.

Function
REQ-018 The block SHALL act as the target-side end of the host debug link: it decodes byte packets from the receiver, performs the memory access, and sends the response bytes through the transmitter.
REQ-019 The packet formats SHALL be:
- Read: 8'h52, then addr[31:24], addr[23:16], addr[15:8], addr[7:0]. Response: rdata as 4 bytes, MSB first.
- Write: 8'h57, then 4 address bytes MSB first, then 4 data bytes MSB first. Response: ACK_BYTE.
REQ-020 Any other first byte SHALL produce the single response ERR_BYTE, with no memory access.
REQ-021 The FSM states SHALL be IDLE, ADDR, WDATA, MEM, SEND and SEND_WAIT.
REQ-022 Transitions:
- IDLE→ADDR on rx_valid with 52/57.
- IDLE→SEND on rx_valid with any other byte.
- ADDR→WDATA after the 4th address byte of a write.
- ADDR→MEM after the 4th address byte of a read.
- WDATA→MEM after the 4th data byte.
REQ-023 Address and data bytes SHALL be shifted in MSB first using a 2-bit byte counter that resets to 0 on each state entry.
REQ-024 In MEM, mem_re or mem_we SHALL assert on the cycle after state entry and hold high until the cycle mem_ack=1, then drop on the next cycle.
REQ-025 For a read, mem_rdata SHALL be captured on mem_ack.
REQ-026 There SHALL be no memory timeout: MEM waits indefinitely for mem_ack.
REQ-027 SEND SHALL pulse tx_start for exactly one cycle, only when tx_busy=0, and then go to SEND_WAIT.
REQ-028 SEND_WAIT SHALL wait one cycle and then until tx_busy=0.
REQ-029 From SEND_WAIT the FSM SHALL return to SEND if response bytes remain, otherwise go to IDLE.
REQ-030 tx_start SHALL never assert on two consecutive cycles.
REQ-031 rx_valid SHALL be ignored in MEM, SEND and SEND_WAIT; bytes arriving there are dropped and no buffering is provided.
REQ-032 In ADDR or WDATA, a 32-bit cycle counter SHALL clear on every rx_valid and increment otherwise.
REQ-033 When that counter reaches TIMEOUT, the FSM SHALL return to IDLE with no memory access and no response.
REQ-034 If rx_valid and the timeout coincide, the byte SHALL win and the counter clears.
REQ-035 mem_addr and mem_wdata SHALL hold their last values outside MEM.
REQ-036 A read response SHALL send four bytes with a latency of at most 2 cycles between the end of each tx_busy and the next tx_start.

Reset
REQ-037 While rst_n=0, and immediately on its fall, the block SHALL force: state IDLE; tx_start=0, tx_data=0, mem_re=0, mem_we=0, busy=0, mem_addr=0, mem_wdata=0; all counters 0.
REQ-038 A reset mid-packet or mid-access SHALL abandon the operation with no response sent.
REQ-039 After rst_n rises, the first rx_valid SHALL be decoded as a command byte.

Verification
REQ-040 Read: rx 52 00 00 10 04, mem_ack with rdata=DEADBEEF -> one mem_re burst at addr 00001004; tx bytes DE, AD, BE, EF in order.
REQ-041 Write: rx 57 00 00 00 08 12 34 56 78 -> mem_we with addr=8 and wdata=12345678 held until mem_ack; then tx 4B.
REQ-042 Unknown command: rx 41 -> tx 3F; no mem_re or mem_we.
REQ-043 Timeout: with TIMEOUT=100, rx 52 00 then a 100-cycle gap -> IDLE and no tx; next rx 41 -> tx 3F.
REQ-044 Backpressure: hold tx_busy=1 for 50 cycles in SEND -> tx_start waits; exactly 4 one-cycle tx_start pulses over the whole read.
REQ-045 Reset mid-access: drop rst_n while mem_re=1 -> mem_re=0 at once; after release, rx 52 packet -> normal response.
